// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD SPI-mode constants, state encoding and frame builder
package sd_pkg;

  localparam int         SD_FRAME_W    = 48;
  localparam logic [7:0] SD_IDLE_BYTE  = 8'hFF;
  localparam logic [1:0] SD_START_BITS = 2'b01;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_POLL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef logic [SD_FRAME_W-1:0] sd_frame_t;

  function automatic sd_frame_t sd_build_frame(input logic [5:0]  index,
                                               input logic [31:0] arg,
                                               input logic [6:0]  crc);
    return {SD_START_BITS, index, arg, crc, 1'b1};
  endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// rtl/sd_spi_shifter.sv - clock-divided SPI mode 0 bit engine, MSB first, up to 48 bits
module sd_spi_shifter
  import sd_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [5:0]            width,
  input  logic [SD_FRAME_W-1:0] tx,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            rx
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic [15:0]           div_cnt;
  logic [5:0]            bits_left;
  logic [SD_FRAME_W-1:0] sh;
  logic                  half_end;

  assign half_end = busy && (div_cnt == DIV_LAST);
  // done marks the final clock of the last bit, so a load on that edge chains without a gap
  assign done     = half_end && sclk && (bits_left == 6'd0);
  assign mosi     = busy ? sh[SD_FRAME_W-1] : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      sclk      <= 1'b0;
      div_cnt   <= '0;
      bits_left <= '0;
      sh        <= '1;
      rx        <= SD_IDLE_BYTE;
    end else if (load) begin
      busy      <= 1'b1;
      sclk      <= 1'b0;
      div_cnt   <= '0;
      bits_left <= width - 6'd1;
      sh        <= tx;
    end else if (half_end) begin
      div_cnt <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
        rx   <= {rx[6:0], miso};
      end else begin
        sclk <= 1'b0;
        if (bits_left == 6'd0) begin
          busy <= 1'b0;
        end else begin
          bits_left <= bits_left - 6'd1;
          sh        <= {sh[SD_FRAME_W-2:0], 1'b1};
        end
      end
    end else if (busy) begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sd_cmd_sender.sv
// rtl/sd_cmd_sender.sv - sends one SD SPI-mode command frame and polls for the R1 byte
module sd_cmd_sender
  import sd_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        finish,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  localparam logic [7:0] POLL_LAST = 8'(RESP_TIMEOUT - 1);

  logic [1:0]            state;
  logic [7:0]            poll_cnt;
  logic                  load;
  logic                  busy;
  logic                  done;
  logic                  accept;
  logic                  poll_again;
  logic [5:0]            width;
  logic [SD_FRAME_W-1:0] tx;
  logic [7:0]            rx;

  assign accept     = (state == ST_IDLE) && start;
  assign poll_again = rx[7] && (poll_cnt != POLL_LAST);
  assign cs_n       = !((state == ST_SHIFT) || (state == ST_POLL));

  always_comb begin
    load  = accept || (done && ((state == ST_SHIFT) || ((state == ST_POLL) && poll_again)));
    width = accept ? 6'(SD_FRAME_W) : 6'd8;
    tx    = accept ? sd_build_frame(cmd_index, cmd_arg, cmd_crc)
                   : {SD_IDLE_BYTE, {(SD_FRAME_W-8){1'b1}}};
  end

  sd_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .width (width),
    .tx    (tx),
    .miso  (miso),
    .sclk  (sclk),
    .mosi  (mosi),
    .busy  (busy),
    .done  (done),
    .rx    (rx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      finish   <= 1'b0;
      timeout  <= 1'b0;
      resp     <= SD_IDLE_BYTE;
      poll_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            finish  <= 1'b0;
            timeout <= 1'b0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (done) begin
            poll_cnt <= '0;
            state    <= ST_POLL;
          end
        end
        ST_POLL: begin
          // the shifter goes idle only after a byte that ends the poll
          if (done && poll_again) begin
            poll_cnt <= poll_cnt + 8'd1;
          end else if (!busy) begin
            state  <= ST_DONE;
            finish <= 1'b1;
            if (rx[7]) begin
              resp    <= SD_IDLE_BYTE;
              timeout <= 1'b1;
            end else begin
              resp <= rx;
            end
          end
        end
        ST_DONE: begin
          if (!start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sender.sv
// tb/tb_sd_cmd_sender.sv - randomized scoreboard bench for sd_cmd_sender
module tb_sd_cmd_sender;

  localparam int CD = 4;
  localparam int RT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        miso = 1'b1;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic        finish, timeout, sclk, mosi, cs_n;
  logic [7:0]  resp;

  sd_cmd_sender #(.CLK_DIV(CD), .RESP_TIMEOUT(RT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .finish    (finish),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .cmd_crc   (cmd_crc),
    .resp      (resp),
    .timeout   (timeout),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] frame;
    logic [7:0]  resp;
    logic        to;
    int          lat;
    int          nbits;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          nbits = 0;
  int          plan_rbyte = 0;
  logic [7:0]  plan_r1 = 8'h00;

  function automatic void chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, actual, expected);
    end
  endfunction

  // card model: 1s during the frame, R1 bits on the planned poll byte (1-based), 1s otherwise
  function automatic logic plan_bit(input int n);
    int p;
    if (n < 48) return 1'b1;
    p = n - 48;
    if (p / 8 + 1 == plan_rbyte) return plan_r1[7 - (p % 8)];
    return 1'b1;
  endfunction

  // monitor: captures SPI traffic, measures latency and pops the scoreboard at each finish
  int          cyc = 0;
  int          t0 = 0;
  logic        ps = 1'b0, pf = 1'b0, pc = 1'b1, poll_ones = 1'b1;
  logic [47:0] cap = '0;

  initial begin
    exp_t e;
    miso = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        nbits = 0;
        ps = 1'b0; pf = 1'b0; pc = 1'b1;
        miso = 1'b1;
      end else begin
        if (pc && !cs_n) begin
          nbits = 0;
          t0 = cyc;
          poll_ones = 1'b1;
        end
        if (!ps && sclk && !cs_n) begin
          if (nbits < 48) cap = {cap[46:0], mosi};
          else if (!mosi) poll_ones = 1'b0;
          nbits++;
        end
        if (!pf && finish) begin
          if (sb.size() == 0) begin
            chk("unexpected_finish", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("frame", cap, e.frame);
            chk("bits_clocked", nbits, e.nbits);
            chk("poll_bytes_ff", poll_ones, 1);
            chk("resp", resp, e.resp);
            chk("timeout", timeout, e.to);
            chk("latency", cyc - t0, e.lat);
            chk("cs_n_at_finish", cs_n, 1);
            chk("sclk_at_finish", sclk, 0);
          end
        end
        ps = sclk; pf = finish; pc = cs_n;
        miso = cs_n ? 1'b1 : plan_bit(nbits);
      end
    end
  end

  // mode: 0 drop start after accept, 1 hold start 50 clocks past finish,
  //       2 drop start mid-poll, 3 abort with reset at bit 20
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                         input logic [47:0] exp_frame, input int rbyte, input logic [7:0] r1,
                         input int mode);
    exp_t e;
    int   n, guard;
    logic hit, held;
    hit     = (rbyte >= 1) && (rbyte <= RT);
    n       = hit ? rbyte : RT;
    e.frame = exp_frame;
    e.resp  = hit ? r1 : 8'hFF;
    e.to    = !hit;
    e.lat   = 1 + 96 * CD + 16 * CD * n;
    e.nbits = 48 + 8 * n;
    plan_rbyte = rbyte;
    plan_r1    = r1;
    if (mode != 3) sb.push_back(e);
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; cmd_crc = crc;
    start = 1'b1;
    guard = 0;
    while (cs_n && guard < 20) begin @(negedge clk); guard++; end
    chk("accept_cs_n", cs_n, 0);
    chk("finish_cleared", finish, 0);
    if (mode == 0) start = 1'b0;
    if (mode == 3) begin
      guard = 0;
      while (nbits < 20 && guard < 2000) begin @(negedge clk); guard++; end
      chk("reach_bit20", nbits >= 20, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 1);
      chk("rst_finish", finish, 0);
      chk("rst_resp", resp, 8'hFF);
      chk("rst_timeout", timeout, 0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end else begin
      if (mode == 2) begin
        guard = 0;
        while (nbits < 52 && guard < 2000) begin @(negedge clk); guard++; end
        start = 1'b0;
      end
      guard = 0;
      while (!finish && guard < e.lat + 100) begin @(negedge clk); guard++; end
      if (!finish) chk("finish_wait", finish, 1);
      if (mode == 1) begin
        held = 1'b1;
        repeat (50) begin
          @(negedge clk);
          held = held & finish & cs_n & !sclk;
        end
        chk("hold_in_done", held, 1);
        start = 1'b0;
      end
    end
  endtask

  initial begin
    logic [5:0]  ridx;
    logic [31:0] rarg;
    logic [6:0]  rcrc;
    repeat (3) @(negedge clk);
    chk("reset_finish", finish, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_resp", resp, 8'hFF);
    chk("reset_sclk", sclk, 0);
    chk("reset_mosi", mosi, 1);
    chk("reset_cs_n", cs_n, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(6'd0,  32'h0,     7'h4A, 48'h40_0000_0000_95, 2, 8'h01, 0);
    run_txn(6'd8,  32'h1AA,   7'h43, 48'h48_0000_01AA_87, 1, 8'h00, 1);
    run_txn(6'd17, 32'h0,     7'h00, 48'h51_0000_0000_01, 0, 8'h00, 0);
    run_txn(6'd24, 32'hDEAD_BEEF, 7'h11, 48'h0, 2, 8'h00, 3);
    run_txn(6'd0,  32'h0,     7'h4A, 48'h40_0000_0000_95, 1, 8'h01, 0);
    run_txn(6'd0,  32'h0,     7'h4A, 48'h40_0000_0000_95, 3, 8'h05, 2);

    for (int i = 0; i < 6; i++) begin
      ridx = 6'($urandom);
      rarg = $urandom;
      rcrc = 7'($urandom);
      run_txn(ridx, rarg, rcrc, {2'b01, ridx, rarg, rcrc, 1'b1},
              $urandom_range(0, RT + 1), {1'b0, 7'($urandom)}, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sender.md
# sd_cmd_sender

Issues one SD-card SPI-mode command frame and collects the R1 response byte. It sits directly upstream of the SD delay/wait counter in the SD controller's init and transfer sequencer. Like that counter, it uses a level start / sticky finish handshake, so the sequencer can chain the two blocks with identical control logic. SPI mode 0, MSB first, SCLK generated from the system clock.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range ≥ 1.
- RESP_TIMEOUT, 8: maximum number of poll bytes clocked while waiting for R1; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level request; sampled only in IDLE.
- finish  out  1  high once the command completes; stays high until the next accepted start.
- cmd_index  in  6  SD command number; captured at accept.
- cmd_arg  in  32  command argument; captured at accept.
- cmd_crc  in  7  CRC7 of the frame; captured at accept.
- resp  out  8  R1 response; 8'hFF on timeout.
- timeout  out  1  high when no R1 arrived within RESP_TIMEOUT bytes.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  SPI data out; idles high.
- miso  in  1  SPI data in.
- cs_n  out  1  chip select, active low.

## Operation
- Reset values: finish=0, timeout=0, resp=8'hFF, sclk=0, mosi=1, cs_n=1, state=IDLE.
- Frame layout, 48 bits, sent MSB first: {2'b01, cmd_index, cmd_arg, cmd_crc, 1'b1}.
- IDLE: cs_n=1, sclk=0, mosi=1.
  - On start=1: capture the frame, clear finish and timeout, go to SHIFT.
- SHIFT: cs_n=0.
  - Send the 48 frame bits; then go to POLL with the poll-byte count at 0.
- POLL: send 8'hFF one byte at a time, shifting miso into a receive register.
  - At the end of each byte, if rx[7]==0: resp=rx, go to DONE.
  - Otherwise, if count==RESP_TIMEOUT-1: resp=8'hFF, timeout=1, go to DONE.
  - Otherwise: count+1 and send the next byte.
- DONE: cs_n=1, finish=1.
  - On start=0: go to IDLE; finish stays 1.
  - If start is still 1: stay in DONE. No re-trigger until start has been low for at least one clock.
- Start dropping during SHIFT or POLL is ignored; the transaction always completes.
- Illegal state encodings go to IDLE.
- Asserting rst_n low at any time forces the reset values immediately. A frame in flight is abandoned and cs_n goes high.

## Timing
- Bit period is 2·CLK_DIV clocks.
  - The first half has sclk low; mosi changes at the start of that half (the falling-edge point).
  - sclk rises for the second half; miso is sampled on the clk edge where sclk rises.
- The first frame bit appears on mosi in the first clock after the accept edge. cs_n falls at the same edge.
- Latency from the start-accept edge to finish=1:
  - 1 + 96·CLK_DIV + 16·CLK_DIV·N clocks, where N is the number of poll bytes clocked (1..RESP_TIMEOUT).
  - CLK_DIV=4, N=2: 1 + 384 + 128 = 513 clocks.
- sclk is low in every clock spent in IDLE or DONE. cs_n is high in those same clocks.
- There is no extra SCLK cycle between SHIFT and POLL.
- resp and timeout update on the same edge that finish rises. They are held until the next accept.

## Structure
- Shared package sd_pkg:
  - state encoding (IDLE, SHIFT, POLL, DONE);
  - SD_FRAME_W=48;
  - SD_IDLE_BYTE=8'hFF;
  - frame start bits 2'b01.
  - The delay counter and the future data-block reader import the same package.
- One sub-module, sd_spi_shifter: a clock-divided bit engine.
  - Interface: load, width (48 or 8), tx data, busy/done, rx byte.
  - sd_cmd_sender instantiates it once and owns only the command/poll FSM.

## Test plan
- CMD0 (index 0, arg 0, crc 7'h4A), CLK_DIV=4, miso returns 0x01 on poll byte 2:
  - mosi carries 40 00 00 00 00 95;
  - resp=0x01, timeout=0, finish at 513 clocks.
- CMD8 (arg 32'h000001AA, crc 7'h43), R1=0x00 on poll byte 1:
  - mosi carries 48 00 00 01 AA 87;
  - resp=0x00, finish at 1+384+64=449 clocks.
- miso held high, RESP_TIMEOUT=8:
  - exactly 8 poll bytes of 0xFF are clocked;
  - resp=0xFF, timeout=1, cs_n=1 at finish.
- start held high 50 clocks after finish:
  - block stays in DONE, no new frame, finish remains 1;
  - after start low 1 clock then high, a second frame starts and finish drops.
- rst_n pulsed low during bit 20 of SHIFT:
  - cs_n=1, sclk=0, mosi=1, finish=0, resp=0xFF within the same clock;
  - the next start sends a complete, correct frame.
- start dropped mid-POLL:
  - the transaction still completes, and finish rises at the nominal latency.
